// File: rtl/voxel_loader.sv
// voxel_loader: unpacks voxel bytes into a 1-bit voxel RAM write stream,
// or zero-fills the whole volume (CLEAR, only with VOXEL_LOADER_CLEAR_EN).
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        begin a load at address 0 (IDLE only)
//   clear_req    begin a zero-fill (IDLE only, ignored without the macro)
//   abort        return to IDLE from any state, no done pulse
//   in_valid     in_data holds a packed byte (bit 0 = lowest address)
//   in_data      eight voxels
//   in_ready     byte accepted this cycle (FETCH only)
//   we/waddr/wdata  voxel RAM write port (waddr/wdata zero when we=0)
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a load or clear completes
//
// Configuration macro: VOXEL_LOADER_CLEAR_EN enables the CLEAR state.

module voxel_loader #(
   parameter int ADDR_BITS = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clear_req,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 we,
   output logic [ADDR_BITS-1:0] waddr,
   output logic                 wdata,
   output logic                 busy,
   output logic                 done
);

`ifdef VOXEL_LOADER_CLEAR_EN
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      CLEAR,
      DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      DONE
   } state_t;

   // Port kept for a stable footprint; nothing reads it in this build.
   logic clear_unused;
   assign clear_unused = clear_req;
`endif

   state_t               state_q;
   state_t               state_d;
   logic [ADDR_BITS-1:0] addr_q;
   logic [ADDR_BITS-1:0] addr_d;
   logic [2:0]           bit_q;
   logic [2:0]           bit_d;
   logic [7:0]           shift_q;
   logic [7:0]           shift_d;

   logic                 addr_last;

   assign addr_last = &addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      bit_d   = bit_q;
      shift_d = shift_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // start has priority over clear_req
               if (start) begin
                  addr_d  = '0;
                  state_d = FETCH;
               end
`ifdef VOXEL_LOADER_CLEAR_EN
               else if (clear_req) begin
                  addr_d  = '0;
                  state_d = CLEAR;
               end
`endif
            end

            FETCH: begin
               if (in_valid) begin
                  shift_d = in_data;
                  bit_d   = '0;
                  state_d = WRITE;
               end
            end

            WRITE: begin
               // addr wraps to 0 after all-ones
               addr_d = addr_q + ADDR_BITS'(1);
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = addr_last ? DONE : FETCH;
               end
            end

`ifdef VOXEL_LOADER_CLEAR_EN
            CLEAR: begin
               addr_d = addr_q + ADDR_BITS'(1);
               if (addr_last) begin
                  state_d = DONE;
               end
            end
`endif

            DONE: begin
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state only.
   always_comb begin
      in_ready = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = 1'b0;
      busy     = (state_q != IDLE);
      done     = 1'b0;

      unique case (state_q)
         FETCH: begin
            in_ready = 1'b1;
         end
         WRITE: begin
            we    = 1'b1;
            waddr = addr_q;
            wdata = shift_q[bit_q];
         end
`ifdef VOXEL_LOADER_CLEAR_EN
         CLEAR: begin
            we    = 1'b1;
            waddr = addr_q;
         end
`endif
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
